// File: rtl/seq_arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_arith_pkg
//  Description : Shared definitions for the sequential arithmetic group
//                (shift-add multiplier and restoring divider): FSM state
//                encodings, default operand/counter widths and a
//                conditional two's-complement negate used for abs/negate.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_arith_pkg;

    // Default operand width and iteration counter width (clog2(WIDTH)+1)
    localparam int c_DEF_WIDTH    = 8;
    localparam int c_DEF_CTRWIDTH = 4;

    // Sequencer states
    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_PREP = 3'd1;
    localparam logic [2:0] c_ST_ITER = 3'd2;
    localparam logic [2:0] c_ST_FIX  = 3'd3;
    localparam logic [2:0] c_ST_DONE = 3'd4;

    // Negate v when en is set, otherwise pass it through. Callers zero-extend
    // their operand to 64 bits and cast the result back to their width, so
    // passing en = msb yields the unsigned magnitude (-2^(W-1) -> 2^(W-1)).
    function automatic logic [63:0] cond_neg(input logic [63:0] v, input logic en);
        return en ? (~v + 64'd1) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : seq_div_step
//  Description : One combinational restoring-division step. Shifts the next
//                dividend bit into the partial remainder and subtracts the
//                divisor when it fits.
//  Ports       : i_rem     [WIDTH:0]   partial remainder
//                i_dq_msb              next dividend bit (dq msb)
//                i_divisor [WIDTH-1:0] divisor magnitude
//                o_rem     [WIDTH:0]   next partial remainder
//                o_q_bit               quotient bit produced by this step
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic             i_dq_msb,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH:0]   o_rem,
    output logic             o_q_bit
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_div_ext;
    logic           w_rem_msb_unused;

    // The remainder is always below the divisor, so its top bit is zero on
    // entry and falls off during the shift.
    assign w_rem_msb_unused = i_rem[WIDTH];
    assign w_shift          = {i_rem[WIDTH-1:0], i_dq_msb};
    assign w_div_ext        = {1'b0, i_divisor};

    always_comb begin
        o_q_bit = 1'b0;
        o_rem   = w_shift;
        if (w_shift >= w_div_ext) begin
            o_q_bit = 1'b1;
            o_rem   = w_shift - w_div_ext;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_div.sv
`default_nettype none
// ============================================================================
//  Module      : seq_div
//  Description : Sequential restoring divider, one quotient bit per cycle.
//                Result latency is WIDTH+2 cycles after start is sampled;
//                divide-by-zero results appear 2 cycles after start.
//  Config      : SEQ_DIV_SIGNED_EN defined   -> signed two's-complement
//                                               (truncating, remainder takes
//                                               the dividend's sign)
//                SEQ_DIV_SIGNED_EN undefined -> unsigned operands
//  Ports       : clk    clock, posedge
//                reset  synchronous active-high reset
//                start  request, sampled in IDLE or DONE only
//                a, b   dividend / divisor
//                q, r   quotient / remainder
//                rdy    result valid, held until the next accepted start
//                busy   high in PREP, ITER and FIX
//                dbz    divide-by-zero flag, valid while rdy is high
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_div
    import seq_arith_pkg::*;
#(
    parameter int WIDTH    = c_DEF_WIDTH,
    parameter int CTRWIDTH = c_DEF_CTRWIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             rdy,
    output logic             busy,
    output logic             dbz
);

    localparam logic [CTRWIDTH-1:0] c_LAST = CTRWIDTH'(WIDTH - 1);

    logic [2:0]          r_state, w_state_d;
    logic [WIDTH-1:0]    r_a, w_a_d;
    logic [WIDTH-1:0]    r_b, w_b_d;
    logic [WIDTH-1:0]    r_dq, w_dq_d;
    logic [WIDTH-1:0]    r_bmag, w_bmag_d;
    logic [WIDTH:0]      r_rem, w_rem_d;
    logic [CTRWIDTH-1:0] r_ctr, w_ctr_d;
    logic [WIDTH-1:0]    r_q, w_q_d;
    logic [WIDTH-1:0]    r_r, w_r_d;
    logic                r_rdy, w_rdy_d;
    logic                r_dbz, w_dbz_d;
`ifdef SEQ_DIV_SIGNED_EN
    logic                r_sign_q, w_sign_q_d;
    logic                r_sign_r, w_sign_r_d;
`endif

    logic [WIDTH:0]      w_step_rem;
    logic                w_step_bit;

    seq_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem     (r_rem),
        .i_dq_msb  (r_dq[WIDTH-1]),
        .i_divisor (r_bmag),
        .o_rem     (w_step_rem),
        .o_q_bit   (w_step_bit)
    );

    always_comb begin
        w_state_d = r_state;
        w_a_d     = r_a;
        w_b_d     = r_b;
        w_dq_d    = r_dq;
        w_bmag_d  = r_bmag;
        w_rem_d   = r_rem;
        w_ctr_d   = r_ctr;
        w_q_d     = r_q;
        w_r_d     = r_r;
        w_rdy_d   = r_rdy;
        w_dbz_d   = r_dbz;
`ifdef SEQ_DIV_SIGNED_EN
        w_sign_q_d = r_sign_q;
        w_sign_r_d = r_sign_r;
`endif
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_a_d     = a;
                    w_b_d     = b;
                    w_state_d = c_ST_PREP;
                end
            end
            c_ST_PREP: begin
`ifdef SEQ_DIV_SIGNED_EN
                w_sign_q_d = r_a[WIDTH-1] ^ r_b[WIDTH-1];
                w_sign_r_d = r_a[WIDTH-1];
                w_dq_d     = WIDTH'(cond_neg(64'(r_a), r_a[WIDTH-1]));
                w_bmag_d   = WIDTH'(cond_neg(64'(r_b), r_b[WIDTH-1]));
`else
                w_dq_d     = r_a;
                w_bmag_d   = r_b;
`endif
                w_rem_d = '0;
                w_ctr_d = '0;
                // A zero divisor skips the iterations; FIX publishes the
                // divide-by-zero result so every result leaves from FIX.
                w_state_d = (r_b == '0) ? c_ST_FIX : c_ST_ITER;
            end
            c_ST_ITER: begin
                w_rem_d = w_step_rem;
                w_dq_d  = {r_dq[WIDTH-2:0], w_step_bit};
                w_ctr_d = r_ctr + CTRWIDTH'(1);
                if (r_ctr == c_LAST) begin
                    w_state_d = c_ST_FIX;
                end
            end
            c_ST_FIX: begin
                // |b| is zero exactly when b was zero
                if (r_bmag == '0) begin
                    w_q_d   = '1;
                    w_r_d   = r_a;
                    w_dbz_d = 1'b1;
                end else begin
`ifdef SEQ_DIV_SIGNED_EN
                    w_q_d = WIDTH'(cond_neg(64'(r_dq), r_sign_q));
                    w_r_d = WIDTH'(cond_neg(64'(r_rem[WIDTH-1:0]), r_sign_r));
`else
                    w_q_d = r_dq;
                    w_r_d = r_rem[WIDTH-1:0];
`endif
                    w_dbz_d = 1'b0;
                end
                w_rdy_d   = 1'b1;
                w_state_d = c_ST_DONE;
            end
            c_ST_DONE: begin
                if (start) begin
                    w_a_d     = a;
                    w_b_d     = b;
                    w_rdy_d   = 1'b0;
                    w_state_d = c_ST_PREP;
                end
            end
            default: begin
                w_state_d = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_dq    <= '0;
            r_bmag  <= '0;
            r_rem   <= '0;
            r_ctr   <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_rdy   <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_a     <= w_a_d;
            r_b     <= w_b_d;
            r_dq    <= w_dq_d;
            r_bmag  <= w_bmag_d;
            r_rem   <= w_rem_d;
            r_ctr   <= w_ctr_d;
            r_q     <= w_q_d;
            r_r     <= w_r_d;
            r_rdy   <= w_rdy_d;
            r_dbz   <= w_dbz_d;
        end
    end

`ifdef SEQ_DIV_SIGNED_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
        end else begin
            r_sign_q <= w_sign_q_d;
            r_sign_r <= w_sign_r_d;
        end
    end
`endif

    assign q    = r_q;
    assign r    = r_r;
    assign rdy  = r_rdy;
    assign dbz  = r_dbz;
    assign busy = (r_state == c_ST_PREP) || (r_state == c_ST_ITER) ||
                  (r_state == c_ST_FIX);

endmodule
`default_nettype wire

// File: tb/tb_seq_div.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_div
//  Description : Self-checking bench for seq_div (WIDTH=8). Expected results
//                come from language-level integer division and are queued
//                when an operation is launched, then compared on rdy.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_div;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       rdy;
    logic       busy;
    logic       dbz;

    always #5 clk = ~clk;

    seq_div #(
        .WIDTH    (8),
        .CTRWIDTH (4)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .q     (q),
        .r     (r),
        .rdy   (rdy),
        .busy  (busy),
        .dbz   (dbz)
    );

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        int         lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] ia, input logic [7:0] ib);
        exp_t e;
        int   sa;
        int   sbv;
        int   qi;
        int   ri;
        if (ib == 8'd0) begin
            e.q   = 8'hFF;
            e.r   = ia;
            e.dbz = 1'b1;
            e.lat = 2;
        end else begin
`ifdef SEQ_DIV_SIGNED_EN
            sa  = $signed(ia);
            sbv = $signed(ib);
`else
            sa  = int'(ia);
            sbv = int'(ib);
`endif
            qi    = sa / sbv;
            ri    = sa % sbv;
            e.q   = qi[7:0];
            e.r   = ri[7:0];
            e.dbz = 1'b0;
            e.lat = 10;
        end
        return e;
    endfunction

    // Launch one division; optionally re-pulse start with other operands
    // while busy (repulse_at = cycle index, -1 for none).
    task automatic run_div(input logic [7:0] ia, input logic [7:0] ib, input int repulse_at);
        exp_t e;
        int   cyc;
        int   busy_cnt;
        sb_q.push_back(model(ia, ib));
        @(negedge clk);
        a     = ia;
        b     = ib;
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        cyc      = 0;
        busy_cnt = busy ? 1 : 0;
        while (!rdy && cyc < 40) begin
            if (cyc == repulse_at) begin
                a     = ~ia;
                b     = ib + 8'd3;
                start = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            a     = ia;
            b     = ib;
            cyc++;
            if (busy) busy_cnt++;
            if (busy && rdy) check_eq("busy_rdy_overlap", 32'd1, 32'd0);
        end
        e = sb_q.pop_front();
        check_eq("rdy",      {31'd0, rdy}, 32'd1);
        check_eq("latency",  cyc, e.lat);
        check_eq("busy_len", busy_cnt, e.lat);
        check_eq("q",        {24'd0, q}, {24'd0, e.q});
        check_eq("r",        {24'd0, r}, {24'd0, e.r});
        check_eq("dbz",      {31'd0, dbz}, {31'd0, e.dbz});
        check_eq("busy_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a     = 8'd0;
        b     = 8'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_q",    {24'd0, q}, 32'd0);
        check_eq("rst_r",    {24'd0, r}, 32'd0);
        check_eq("rst_rdy",  {31'd0, rdy}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_dbz",  {31'd0, dbz}, 32'd0);
        reset = 1'b0;

        run_div(8'd100, 8'd7, -1);
        run_div(8'h9C,  8'd7, -1);     // -100 / 7
        run_div(8'd100, 8'hF9, -1);    // 100 / -7
        run_div(8'h9C,  8'hF9, -1);    // -100 / -7
        run_div(8'h80,  8'hFF, -1);    // -128 / -1
        run_div(8'h80,  8'd1, -1);     // -128 / 1
        run_div(8'd5,   8'd0, -1);     // divide by zero
        run_div(8'd9,   8'd3, -1);
        run_div(8'hF0,  8'd7, -1);
        run_div(8'd255, 8'd1, -1);
        run_div(8'd100, 8'd7, 4);      // start re-pulsed mid-ITER
        run_div(8'd1,   8'd200, -1);

        // Reset mid-ITER aborts and clears every output on that edge
        @(negedge clk);
        a     = 8'd77;
        b     = 8'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("abort_q",    {24'd0, q}, 32'd0);
        check_eq("abort_r",    {24'd0, r}, 32'd0);
        check_eq("abort_rdy",  {31'd0, rdy}, 32'd0);
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_dbz",  {31'd0, dbz}, 32'd0);
        reset = 1'b0;
        run_div(8'd9, 8'd3, -1);
        run_div(8'd100, 8'd7, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
